// File: rtl/vproc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_seq_pkg
//  Description : Shared types for the VProc bus sequencer: state encoding,
//                latched-command record and beat-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package vproc_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WDATA  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_TICKS  = 2'd3
    } vseq_state_e;

    // Widest supported fields; the sequencer zero-extends its configured
    // widths into these, so ADDR_WIDTH/BURST_WIDTH/TICK_WIDTH must not exceed them.
    localparam int c_CMD_ADDR_MAX  = 64;
    localparam int c_CMD_BURST_MAX = 32;
    localparam int c_CMD_TICK_MAX  = 32;

    // Latched command. While the command runs, 'addr' is the current beat
    // address, 'burst' the number of beats still to do and 'ticks' the
    // remaining idle cycles.
    typedef struct packed {
        logic [c_CMD_ADDR_MAX-1:0]  addr;
        logic                       we;
        logic                       rd;
        logic [c_CMD_BURST_MAX-1:0] burst;
        logic [c_CMD_TICK_MAX-1:0]  ticks;
    } vseq_cmd_t;

    // A burst field of 0 or 1 both mean one beat
    function automatic logic [c_CMD_BURST_MAX-1:0] beat_count(
        input logic [c_CMD_BURST_MAX-1:0] burst
    );
        return (burst == '0) ? c_CMD_BURST_MAX'(1) : burst;
    endfunction

endpackage : vproc_seq_pkg
`default_nettype wire

// File: rtl/vproc_irq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_irq_monitor
//  Description : Samples the interrupt vector every cycle and emits a
//                one-cycle event carrying the new value whenever it changes.
//  Revision    : 1.0  initial release
// ============================================================================
module vproc_irq_monitor #(
    parameter int INT_WIDTH = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [INT_WIDTH-1:0] Interrupt,
    output logic                 IrqEvent,
    output logic [INT_WIDTH-1:0] IrqValue
);

    logic [INT_WIDTH-1:0] r_sample;
    logic                 r_event;
    logic [INT_WIDTH-1:0] r_value;

    // Compare the new sample with the previous one; pulse and latch on change
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sample <= '0;
            r_event  <= 1'b0;
            r_value  <= '0;
        end else begin
            r_sample <= Interrupt;
            r_event  <= (Interrupt != r_sample);
            if (Interrupt != r_sample) begin
                r_value <= Interrupt;
            end
        end
    end

    assign IrqEvent = r_event;
    assign IrqValue = r_value;

endmodule : vproc_irq_monitor
`default_nettype wire

// File: rtl/vproc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_bus_sequencer
//  Description : Executes queued single/burst read/write and idle-tick
//                commands on the VProc memory-mapped bus. Read beats are
//                returned on a response stream; interrupt changes are
//                reported as events.
//  Options     : VPROC_ACK_TIMEOUT_EN - abort a beat whose ack does not
//                arrive within ACK_TIMEOUT cycles and pulse TimeoutErr.
//  Revision    : 1.0  initial release
// ============================================================================
module vproc_bus_sequencer
    import vproc_seq_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_WIDTH     = 12,
    parameter int BURST_ADDR_INCR = 1,
    parameter int TICK_WIDTH      = 16,
    parameter int INT_WIDTH       = 3
`ifdef VPROC_ACK_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT     = 256
`endif
) (
    input  logic                   Clk,
    input  logic                   Reset,
    // command port
    input  logic                   CmdValid,
    output logic                   CmdReady,
    input  logic [ADDR_WIDTH-1:0]  CmdAddr,
    input  logic                   CmdWE,
    input  logic                   CmdRD,
    input  logic [BURST_WIDTH-1:0] CmdBurst,
    input  logic [TICK_WIDTH-1:0]  CmdTicks,
    // write data stream
    input  logic                   WDValid,
    output logic                   WDReady,
    input  logic [DATA_WIDTH-1:0]  WDData,
    // read response stream
    output logic                   RDValid,
    output logic                   RDLast,
    output logic [DATA_WIDTH-1:0]  RDData,
    // VProc bus
    output logic [ADDR_WIDTH-1:0]  Addr,
    output logic                   WE,
    output logic                   RD,
    output logic [DATA_WIDTH-1:0]  DataOut,
    input  logic [DATA_WIDTH-1:0]  DataIn,
    input  logic                   WRAck,
    input  logic                   RDAck,
    output logic                   BurstFirst,
    output logic                   BurstLast,
    // interrupts and status
    input  logic [INT_WIDTH-1:0]   Interrupt,
    output logic                   IrqEvent,
    output logic [INT_WIDTH-1:0]   IrqValue,
    output logic                   Busy
`ifdef VPROC_ACK_TIMEOUT_EN
    ,
    output logic                   TimeoutErr
`endif
);

    localparam logic [1:0] c_IDLE   = ST_IDLE;
    localparam logic [1:0] c_WDATA  = ST_WDATA;
    localparam logic [1:0] c_ACCESS = ST_ACCESS;
    localparam logic [1:0] c_TICKS  = ST_TICKS;

    localparam logic [c_CMD_ADDR_MAX-1:0]  c_ADDR_INCR = c_CMD_ADDR_MAX'(BURST_ADDR_INCR);
    localparam logic [c_CMD_BURST_MAX-1:0] c_ONE_BEAT  = c_CMD_BURST_MAX'(1);
    localparam logic [c_CMD_TICK_MAX-1:0]  c_ONE_TICK  = c_CMD_TICK_MAX'(1);

`ifdef VPROC_ACK_TIMEOUT_EN
    localparam int                  c_TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
`endif

    logic [1:0]            r_state;
    vseq_cmd_t             r_cmd;
    logic                  r_multi;    // command has two or more beats
    logic                  r_first;    // current beat is beat 0
    logic                  r_we;
    logic                  r_rd;
    logic [DATA_WIDTH-1:0] r_dataout;
    logic                  r_rdvalid;
    logic                  r_rdlast;
    logic [DATA_WIDTH-1:0] r_rddata;
`ifdef VPROC_ACK_TIMEOUT_EN
    logic [c_TMO_W-1:0]    r_tmo;
    logic                  r_tmoerr;
`endif

    logic w_ack;
    logic w_final;

    // Only an ack matching the active strobe completes a beat
    assign w_ack   = (r_rd & RDAck) | (r_we & WRAck);
    assign w_final = (r_cmd.burst == c_ONE_BEAT);

    // Command sequencing: accept, gather write data, run beats, idle ticks
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= c_IDLE;
            r_cmd     <= '0;
            r_multi   <= 1'b0;
            r_first   <= 1'b0;
            r_we      <= 1'b0;
            r_rd      <= 1'b0;
            r_dataout <= '0;
            r_rdvalid <= 1'b0;
            r_rdlast  <= 1'b0;
            r_rddata  <= '0;
`ifdef VPROC_ACK_TIMEOUT_EN
            r_tmo     <= '0;
            r_tmoerr  <= 1'b0;
`endif
        end else begin
            r_rdvalid <= 1'b0;
            r_rdlast  <= 1'b0;
`ifdef VPROC_ACK_TIMEOUT_EN
            r_tmoerr  <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    if (CmdValid) begin
                        r_cmd.addr  <= c_CMD_ADDR_MAX'(CmdAddr);
                        r_cmd.we    <= CmdWE;
                        r_cmd.rd    <= CmdRD & ~CmdWE;
                        r_cmd.burst <= beat_count(c_CMD_BURST_MAX'(CmdBurst));
                        r_cmd.ticks <= c_CMD_TICK_MAX'(CmdTicks);
                        r_multi     <= (CmdBurst > BURST_WIDTH'(1));
                        r_first     <= 1'b1;
`ifdef VPROC_ACK_TIMEOUT_EN
                        r_tmo       <= '0;
`endif
                        if (CmdWE) begin
                            r_state <= c_WDATA;
                        end else if (CmdRD) begin
                            r_rd    <= 1'b1;
                            r_state <= c_ACCESS;
                        end else if (CmdTicks != '0) begin
                            r_state <= c_TICKS;
                        end
                    end
                end

                c_WDATA: begin
                    if (WDValid) begin
                        r_dataout <= WDData;
                        r_we      <= 1'b1;
                        r_state   <= c_ACCESS;
                    end
                end

                c_ACCESS: begin
                    if (w_ack) begin
                        r_first <= 1'b0;
`ifdef VPROC_ACK_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                        if (r_cmd.rd) begin
                            r_rdvalid <= 1'b1;
                            r_rddata  <= DataIn;
                            r_rdlast  <= w_final;
                        end
                        if (w_final) begin
                            r_we    <= 1'b0;
                            r_rd    <= 1'b0;
                            r_state <= (r_cmd.ticks != '0) ? c_TICKS : c_IDLE;
                        end else begin
                            r_cmd.addr  <= r_cmd.addr + c_ADDR_INCR;
                            r_cmd.burst <= r_cmd.burst - c_ONE_BEAT;
                            if (r_cmd.we) begin
                                r_we    <= 1'b0;
                                r_state <= c_WDATA;
                            end
                        end
                    end
`ifdef VPROC_ACK_TIMEOUT_EN
                    else if (r_tmo == c_TMO_LAST) begin
                        // Abandon the command: no more beats, no RDLast, no ticks
                        r_we     <= 1'b0;
                        r_rd     <= 1'b0;
                        r_tmo    <= '0;
                        r_tmoerr <= 1'b1;
                        r_state  <= c_IDLE;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
`endif
                end

                c_TICKS: begin
                    if (r_cmd.ticks <= c_ONE_TICK) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cmd.ticks <= r_cmd.ticks - c_ONE_TICK;
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign CmdReady   = (r_state == c_IDLE);
    assign Busy       = (r_state != c_IDLE);
    assign WDReady    = (r_state == c_WDATA) & WDValid;
    assign Addr       = ADDR_WIDTH'(r_cmd.addr);
    assign WE         = r_we;
    assign RD         = r_rd;
    assign DataOut    = r_dataout;
    assign RDValid    = r_rdvalid;
    assign RDLast     = r_rdlast;
    assign RDData     = r_rddata;
    assign BurstFirst = r_multi & r_first & (r_we | r_rd);
    assign BurstLast  = r_multi & w_final & (r_we | r_rd);
`ifdef VPROC_ACK_TIMEOUT_EN
    assign TimeoutErr = r_tmoerr;
`endif

    vproc_irq_monitor #(
        .INT_WIDTH (INT_WIDTH)
    ) u_irq_monitor (
        .Clk       (Clk),
        .Reset     (Reset),
        .Interrupt (Interrupt),
        .IrqEvent  (IrqEvent),
        .IrqValue  (IrqValue)
    );

endmodule : vproc_bus_sequencer
`default_nettype wire
